ahb_decoder: RTL
================

// Module: ahb_decoder
// PURPOSE
//  AHB-Lite address decoder, response multiplexer and default slave between the CPU master port and
//  the memory/peripheral slaves (RAM, GPIO, ...). Drives per-slave HSEL and the shared HREADY.
//  Returns the selected slave's data-phase HRDATA/HRESP to the master.
//  Unmapped NONSEQ/SEQ transfers get a two-cycle AHB ERROR response.
// PARAMETERS
//  SLV_N     3                                      number of slaves (1..8)
//  SLV_BASE  {32'h00007F10,32'h00007F00,32'h0}      packed bases; slave i at [32*i +: 32]
//  SLV_MASK  {32'hFFFFFFF0,32'hFFFFFFF0,32'hFFFFC000} packed masks; hit_i = (HADDR & MASK_i) == BASE_i
//  TIMEOUT   255                                    stall limit in cycles (timeout feature only)
// PORTS
//  HCLK        in   1         bus clock
//  HRESETn     in   1         synchronous active-low reset
//  HADDR       in   32        master address phase address
//  HTRANS      in   2         master transfer type
//  HSEL        out  SLV_N     one-hot slave select, address phase, combinational
//  HREADY      out  1         to master and all slaves' HREADY inputs
//  HRDATA      out  32        to master
//  HRESP       out  1         to master
//  S_HRDATA    in   32*SLV_N  slave read data, slave i at [32*i +: 32]
//  S_HREADYOUT in   SLV_N     slave ready
//  S_HRESP     in   SLV_N     slave response
// BEHAVIOUR
//  - Decode: lowest-index hit wins; HSEL is one-hot or zero. Driven regardless of HTRANS;
//    slaves qualify it with HTRANS/HREADY.
//  - Unmapped: no hit while HTRANS is NONSEQ/SEQ selects the default slave (sel_def).
//  - Data-phase select: sel_r/sel_def_r are loaded from the decode on every cycle with HREADY=1
//    and held while HREADY=0.
//  - Mux, slave selected: HRDATA/HREADY/HRESP = S_HRDATA/S_HREADYOUT/S_HRESP[sel_r].
//  - Mux, default slave or nothing selected: HRDATA=0, readiness/response from the default-slave FSM.
//  - Default-slave FSM, states DS_OKAY, DS_ERR1, DS_ERR2:
//     DS_OKAY: HREADY=1, HRESP=0. Goes to DS_ERR1 when HREADY=1 and an unmapped NONSEQ/SEQ
//              is in the address phase.
//     DS_ERR1: HREADY=0, HRESP=1. Always goes to DS_ERR2 next cycle.
//     DS_ERR2: HREADY=1, HRESP=1. Goes to DS_ERR1 if another unmapped NONSEQ/SEQ is sampled;
//              otherwise goes to DS_OKAY.
//  - IDLE/BUSY to unmapped space: zero-wait OKAY, no error.
//  - Back-to-back transfers: a new address is decoded during the last cycle of the previous data
//    phase (HREADY=1). There is no bubble between slaves.
//  - Reset, including mid-transfer: sel_r = none, FSM = DS_OKAY, HREADY=1, HRESP=0, HRDATA=0.
//    HSEL stays combinational from HADDR.
// CONFIGURATION
//  SM_AHB_TIMEOUT_EN defined:
//   - A counter runs while a real slave is selected in the data phase and its S_HREADYOUT=0.
//     It clears whenever HREADY=1.
//   - When the count reaches TIMEOUT, the decoder overrides that slave with DS_ERR1 then DS_ERR2
//     (ERROR to master). HREADY=1 in DS_ERR2 ends the transfer for the hung slave as well.
//  SM_AHB_TIMEOUT_EN undefined:
//   - No counter and no override. A stalled slave stalls the bus indefinitely. TIMEOUT is ignored.
// STRUCTURE
//  - ahb_lite.vh: add DS_OKAY/DS_ERR1/DS_ERR2 encodings next to the existing HTRANS_* defines.
//  - sm_settings.vh: holds the SM_AHB_TIMEOUT_EN switch.
//  - Sub-module ahb_default_slave: the FSM and optional timeout counter; outputs ds_ready, ds_resp.
//  - Registers use the existing sm_register_we / sm_register_c primitives.
// TESTING
//  1. Reset with HTRANS=NONSEQ to 0x7F04 -> HREADY=1, HRESP=0, HRDATA=0 while HRESETn=0;
//     HSEL=3'b010.
//  2. NONSEQ read 0x7F00, GPIO S_HRDATA=0x0000_00A5, zero-wait -> HSEL=3'b010;
//     next cycle HRDATA=0xA5, HRESP=0.
//  3. NONSEQ 0x0000_0010 (RAM) then 0x7F10 back-to-back, RAM HREADYOUT=0 for 2 cycles ->
//     HREADY low 2 cycles; second address held; HSEL=3'b100 once HREADY=1.
//  4. NONSEQ 0x8000_0000 (unmapped) -> next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1,
//     then OKAY. Same address with IDLE -> OKAY, zero wait.
//  5. Two consecutive unmapped NONSEQs -> ERR1, ERR2, ERR1, ERR2 with no OKAY cycle between.
//  6. SM_AHB_TIMEOUT_EN, TIMEOUT=4, GPIO HREADYOUT stuck 0 -> ERROR pair issued after 4 stall cycles,
//     next transfer decodes normally. Without the macro the bus stays stalled for 100 cycles.

Source files
------------

// File: rtl/ahb_decoder_pkg.sv
// ----------------------------------------------------------------------------
// ahb_decoder_pkg
//   Shared AHB-Lite definitions for the address decoder slice:
//   - HTRANS encodings
//   - default-slave FSM state encodings (DS_OKAY / DS_ERR1 / DS_ERR2)
//   - helper that tells whether a transfer type carries a real transfer
// ----------------------------------------------------------------------------
package ahb_decoder_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        DS_OKAY = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    // NONSEQ and SEQ are real transfers; IDLE and BUSY are not.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ----------------------------------------------------------------------------
// ahb_default_slave
//   Default-slave FSM that produces the two-cycle AHB ERROR response for
//   unmapped transfers and, when SM_AHB_TIMEOUT_EN is defined, for a real
//   slave that stalls the bus for TIMEOUT cycles.
//
//   Configuration macro: SM_AHB_TIMEOUT_EN (defined -> stall timeout enabled)
//
// Ports
//   HCLK       in   bus clock
//   HRESETn    in   synchronous active-low reset
//   bus_ready  in   shared HREADY as seen by master and slaves
//   err_req    in   unmapped NONSEQ/SEQ present in the address phase
//   stall      in   real slave selected in data phase with HREADYOUT=0
//   ds_ready   out  default-slave HREADY contribution
//   ds_resp    out  default-slave HRESP contribution
//   ds_active  out  FSM is issuing an ERROR response (overrides slave mux)
// ----------------------------------------------------------------------------
module ahb_default_slave
    import ahb_decoder_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic bus_ready,
    input  logic err_req,
    input  logic stall,
    output logic ds_ready,
    output logic ds_resp,
    output logic ds_active
);

    ds_state_t state;
    ds_state_t state_next;
    logic      timeout_hit;

`ifdef SM_AHB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stall_cnt;

    // The stall that would bring the count to TIMEOUT triggers the error.
    assign timeout_hit = stall && (state == DS_OKAY) &&
                         (stall_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            stall_cnt <= '0;
        end else if (bus_ready) begin
            stall_cnt <= '0;
        end else if (stall && (state == DS_OKAY)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    logic unused_stall;

    assign unused_stall = stall;
    assign timeout_hit  = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, matching real flops.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= DS_OKAY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        ds_ready   = 1'b1;
        ds_resp    = 1'b0;
        case (state)
            DS_OKAY: begin
                if ((bus_ready && err_req) || timeout_hit) begin
                    state_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                ds_ready   = 1'b0;
                ds_resp    = 1'b1;
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                ds_resp    = 1'b1;
                // HREADY is high here, so the next address phase is sampled.
                state_next = err_req ? DS_ERR1 : DS_OKAY;
            end
            default: begin
                state_next = DS_OKAY;
            end
        endcase
    end

    assign ds_active = (state != DS_OKAY);

endmodule

// File: rtl/ahb_decoder.sv
// ----------------------------------------------------------------------------
// ahb_decoder
//   AHB-Lite address decoder, response multiplexer and default slave between
//   the CPU master port and SLV_N slaves.
//
//   Configuration macro: SM_AHB_TIMEOUT_EN (enables the stalled-slave timeout
//   inside ahb_default_slave; TIMEOUT is ignored otherwise).
//
// Ports
//   HCLK         in   bus clock
//   HRESETn      in   synchronous active-low reset
//   HADDR[31:0]  in   address-phase address from master
//   HTRANS[1:0]  in   transfer type from master
//   HSEL         out  one-hot slave select (combinational, address phase)
//   HREADY       out  shared ready to master and all slaves
//   HRDATA[31:0] out  read data to master
//   HRESP        out  response to master
//   S_HRDATA     in   slave read data, slave i at [32*i +: 32]
//   S_HREADYOUT  in   per-slave ready
//   S_HRESP      in   per-slave response
// ----------------------------------------------------------------------------
module ahb_decoder
    import ahb_decoder_pkg::*;
#(
    parameter int                  SLV_N    = 3,
    parameter logic [32*SLV_N-1:0] SLV_BASE = {32'h00007F10, 32'h00007F00, 32'h00000000},
    parameter logic [32*SLV_N-1:0] SLV_MASK = {32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFC000},
    parameter int                  TIMEOUT  = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    output logic [SLV_N-1:0]      HSEL,
    output logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    input  logic [32*SLV_N-1:0]   S_HRDATA,
    input  logic [SLV_N-1:0]      S_HREADYOUT,
    input  logic [SLV_N-1:0]      S_HRESP
);

    logic [SLV_N-1:0] hsel_dec;
    logic             unmapped_req;
    logic [SLV_N-1:0] sel_r;
    logic             sel_def_r;

    logic [31:0]      s_rdata;
    logic             s_ready;
    logic             s_resp;
    logic             use_ds;

    logic             ds_ready;
    logic             ds_resp;
    logic             ds_active;

    // Walk from the highest index down so the lowest-index hit is written last.
    always_comb begin
        hsel_dec = '0;
        for (int i = SLV_N - 1; i >= 0; i--) begin
            if ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                hsel_dec    = '0;
                hsel_dec[i] = 1'b1;
            end
        end
    end

    assign HSEL         = hsel_dec;
    assign unmapped_req = (hsel_dec == '0) && trans_active(HTRANS);

    // Data-phase select follows the address phase only when the bus advances.
    // NOTE: the reset branch is sampled on the clock edge (synchronous reset),
    // so the registers clear on the first edge with HRESETn low.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sel_r     <= '0;
            sel_def_r <= 1'b0;
        end else if (HREADY) begin
            sel_r     <= hsel_dec;
            sel_def_r <= unmapped_req;
        end
    end

    // sel_r is one-hot or zero, so an OR-reduction acts as the slave mux.
    always_comb begin
        s_rdata = '0;
        s_ready = 1'b0;
        s_resp  = 1'b0;
        for (int i = 0; i < SLV_N; i++) begin
            if (sel_r[i]) begin
                s_rdata = s_rdata | S_HRDATA[32*i +: 32];
                s_ready = s_ready | S_HREADYOUT[i];
                s_resp  = s_resp  | S_HRESP[i];
            end
        end
    end

    // The default slave owns the response whenever nothing real is selected,
    // or while it is overriding a hung slave with an ERROR pair.
    assign use_ds = sel_def_r || (sel_r == '0) || ds_active;

    always_comb begin
        if (use_ds) begin
            HRDATA = '0;
            HREADY = ds_ready;
            HRESP  = ds_resp;
        end else begin
            HRDATA = s_rdata;
            HREADY = s_ready;
            HRESP  = s_resp;
        end
    end

    ahb_default_slave #(
        .TIMEOUT (TIMEOUT)
    ) u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus_ready (HREADY),
        .err_req   (unmapped_req),
        .stall     ((sel_r != '0) && !s_ready),
        .ds_ready  (ds_ready),
        .ds_resp   (ds_resp),
        .ds_active (ds_active)
    );

endmodule
